// File: rtl/rotate_sequencer.sv
// Command front-end for an external 16-bit right-rotating barrel rotator: accepts a
// rotate command, repeats it, and streams each cumulative result with backpressure.
module rotate_sequencer #(
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_amt,
    input  logic             in_left,
    input  logic [REP_W-1:0] in_reps,
    output logic [15:0]      shf_a,
    output logic [3:0]       shf_n,
    input  logic [15:0]      shf_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      shf_a_q, shf_a_d;
    logic [3:0]       shf_n_q, shf_n_d;
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign shf_a     = shf_a_q;
    assign shf_n     = shf_n_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        shf_a_d     = shf_a_q;
        shf_n_d     = shf_n_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shf_a_d = in_data;
                    // A left rotate by k equals a right rotate by (16 - k) mod 16.
                    shf_n_d = in_left ? (4'd0 - in_amt) : in_amt;
                    cnt_d   = in_reps;
                    if (in_reps != '0) begin
                        state_d = ROT;
                    end else begin
                        out_data_d  = in_data;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            ROT: begin
                out_data_d  = shf_w;
                out_last_d  = (cnt_q == REP_W'(1));
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        // Feed the emitted word back so the next step accumulates.
                        shf_a_d = out_data_q;
                        cnt_d   = cnt_q - REP_W'(1);
                        state_d = ROT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shf_a_q     <= '0;
            shf_n_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shf_a_q     <= shf_a_d;
            shf_n_q     <= shf_n_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer with a behavioural rotator and a
// reference model that rotates bit by bit by k*amt positions.
module tb_rotate_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic        in_left = 1'b0;
    logic [3:0]  in_reps = '0;
    logic [15:0] shf_a;
    logic [3:0]  shf_n;
    logic [15:0] shf_w;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] obs_d[$];
    logic        obs_l[$];
    int          obs_lat[$];
    logic [3:0]  got_shfn;
    logic        timed_out, held_ok, ready_after, idle_after;

    always #5 clk = ~clk;

    rotate_sequencer #(.REP_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_left(in_left), .in_reps(in_reps),
        .shf_a(shf_a), .shf_n(shf_n), .shf_w(shf_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    // Rotator contract: shf_w[i] = shf_a[(i + shf_n) mod 16].
    always_comb begin
        shf_w = '0;
        for (int i = 0; i < 16; i++) shf_w[i] = shf_a[(i + int'(shf_n)) % 16];
    end

    function automatic logic [15:0] model_beat(logic [15:0] d, int amt, logic left, int k);
        logic [15:0] x;
        int s;
        x = d;
        s = (k * amt) % 16;
        for (int i = 0; i < s; i++) x = left ? {x[14:0], x[15]} : {x[0], x[15:1]};
        return x;
    endfunction

    task automatic drive_cmd(input logic [15:0] d, input logic [3:0] amt, input logic left,
                             input logic [3:0] reps, input int stall);
        int nb, edges;
        obs_d.delete(); obs_l.delete(); obs_lat.delete();
        timed_out = 1'b0; held_ok = 1'b1; ready_after = 1'b0; idle_after = 1'b0;
        edges = 0;
        while (!in_ready && edges < 50) begin @(posedge clk); #1; edges++; end
        if (!in_ready) begin timed_out = 1'b1; return; end
        in_valid = 1'b1; in_data = d; in_amt = amt; in_left = left; in_reps = reps;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'($urandom); in_amt = 4'($urandom);
        in_left = 1'($urandom); in_reps = 4'($urandom);
        got_shfn = shf_n;
        nb = (reps == 0) ? 1 : int'(reps);
        for (int b = 0; b < nb; b++) begin
            edges = 1;
            while (!out_valid && edges < 20) begin @(posedge clk); #1; edges++; end
            if (!out_valid) begin timed_out = 1'b1; return; end
            obs_lat.push_back(edges);
            obs_d.push_back(out_data);
            obs_l.push_back(out_last);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    if (out_valid !== 1'b1 || out_data !== obs_d[0] || out_last !== obs_l[0] ||
                        in_ready !== 1'b0 || shf_n !== got_shfn) held_ok = 1'b0;
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        ready_after = in_ready;
        idle_after  = !busy && !out_valid;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", out_last); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        n_checks++; if (shf_a !== 16'h0000 || shf_n !== 4'h0) begin n_fail++; $display("FAIL reset_shf got=%h/%h exp=0000/0", shf_a, shf_n); end
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b/%b exp=0/0", in_ready, busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_right_rotate();
        drive_cmd(16'h0001, 4'd1, 1'b0, 4'd1, 0);
        n_checks++; if (timed_out !== 1'b0 || obs_d.size() != 1) begin n_fail++; $display("FAIL right_beats got=%0d exp=1", obs_d.size()); end
        else begin
            n_checks++; if (obs_d[0] !== 16'h8000 || obs_l[0] !== 1'b1) begin n_fail++; $display("FAIL right_data got=%h/%b exp=8000/1", obs_d[0], obs_l[0]); end
            n_checks++; if (obs_lat[0] != 2) begin n_fail++; $display("FAIL right_latency got=%0d exp=2", obs_lat[0]); end
        end
        n_checks++; if (got_shfn !== 4'd1) begin n_fail++; $display("FAIL right_shfn got=%0d exp=1", got_shfn); end
    endtask

    task automatic test_left_repeat();
        logic [15:0] exp_d[3] = '{16'h0010, 16'h0100, 16'h1000};
        drive_cmd(16'h0001, 4'd4, 1'b1, 4'd3, 0);
        n_checks++; if (got_shfn !== 4'd12) begin n_fail++; $display("FAIL left_shfn got=%0d exp=12", got_shfn); end
        n_checks++; if (timed_out !== 1'b0 || obs_d.size() != 3) begin n_fail++; $display("FAIL left_beats got=%0d exp=3", obs_d.size()); end
        else begin
            for (int b = 0; b < 3; b++) begin
                n_checks++;
                if (obs_d[b] !== exp_d[b] || obs_l[b] !== (b == 2) || obs_lat[b] != 2) begin
                    n_fail++; $display("FAIL left_beat%0d got=%h/%b/%0d exp=%h/%b/2", b, obs_d[b], obs_l[b], obs_lat[b], exp_d[b], b == 2);
                end
            end
        end
        n_checks++; if (ready_after !== 1'b1 || idle_after !== 1'b1) begin n_fail++; $display("FAIL left_ready_after got=%b/%b exp=1/1", ready_after, idle_after); end
    endtask

    task automatic test_backpressure();
        drive_cmd(16'h00F0, 4'd8, 1'b0, 4'd2, 5);
        n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold got=%b exp=1", held_ok); end
        n_checks++; if (timed_out !== 1'b0 || obs_d.size() != 2) begin n_fail++; $display("FAIL bp_beats got=%0d exp=2", obs_d.size()); end
        else begin
            n_checks++; if (obs_d[0] !== 16'hF000 || obs_l[0] !== 1'b0) begin n_fail++; $display("FAIL bp_beat0 got=%h/%b exp=f000/0", obs_d[0], obs_l[0]); end
            n_checks++; if (obs_d[1] !== 16'h00F0 || obs_l[1] !== 1'b1) begin n_fail++; $display("FAIL bp_beat1 got=%h/%b exp=00f0/1", obs_d[1], obs_l[1]); end
        end
    endtask

    task automatic test_boundaries();
        drive_cmd(16'hA5C3, 4'd5, 1'b0, 4'd0, 0);
        n_checks++; if (timed_out !== 1'b0 || obs_d.size() != 1) begin n_fail++; $display("FAIL pass_beats got=%0d exp=1", obs_d.size()); end
        else begin
            n_checks++;
            if (obs_d[0] !== 16'hA5C3 || obs_l[0] !== 1'b1 || obs_lat[0] != 1) begin
                n_fail++; $display("FAIL pass_beat got=%h/%b/%0d exp=a5c3/1/1", obs_d[0], obs_l[0], obs_lat[0]);
            end
        end
        drive_cmd(16'hA5C3, 4'd0, 1'b1, 4'd2, 0);
        n_checks++; if (got_shfn !== 4'd0) begin n_fail++; $display("FAIL left0_shfn got=%0d exp=0", got_shfn); end
        n_checks++; if (timed_out !== 1'b0 || obs_d.size() != 2) begin n_fail++; $display("FAIL left0_beats got=%0d exp=2", obs_d.size()); end
        else begin
            n_checks++;
            if (obs_d[0] !== 16'hA5C3 || obs_d[1] !== 16'hA5C3 || obs_l[0] !== 1'b0 || obs_l[1] !== 1'b1) begin
                n_fail++; $display("FAIL left0_data got=%h,%h/%b%b exp=a5c3,a5c3/01", obs_d[0], obs_d[1], obs_l[0], obs_l[1]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic stray;
        int edges;
        edges = 0;
        while (!in_ready && edges < 50) begin @(posedge clk); #1; edges++; end
        in_valid = 1'b1; in_data = 16'h1234; in_amt = 4'd3; in_left = 1'b0; in_reps = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_in_hold got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midop_ready_in_rst got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0 || shf_a !== 16'h0 || shf_n !== 4'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset_state got=%b/%b/%h/%h/%h/%b exp=0/0/0000/0000/0/0", out_valid, out_last, out_data, shf_a, shf_n, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready_after got=%b exp=1", in_ready); end
        stray = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) stray = 1'b1; end
        out_ready = 1'b0;
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL midop_stray_beat got=%b exp=0", stray); end
        drive_cmd(16'h8000, 4'd1, 1'b1, 4'd1, 0);
        n_checks++;
        if (timed_out !== 1'b0 || obs_d.size() != 1 || obs_d[0] !== 16'h0001 || obs_l[0] !== 1'b1) begin
            n_fail++; $display("FAIL midop_new_cmd got_beats=%0d exp=1 beat 0001/1", obs_d.size());
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [3:0]  amt, reps;
        logic        left;
        int          nb, k, stall, exp_n;
        logic [15:0] e;
        for (int t = 0; t < 30; t++) begin
            d = 16'($urandom); amt = 4'($urandom); left = 1'($urandom);
            reps = 4'($urandom_range(0, 15)); stall = int'($urandom_range(0, 3));
            drive_cmd(d, amt, left, reps, stall);
            nb = (reps == 0) ? 1 : int'(reps);
            exp_n = left ? (16 - int'(amt)) % 16 : int'(amt);
            n_checks++;
            if (timed_out !== 1'b0 || obs_d.size() != nb || got_shfn !== 4'(exp_n) || held_ok !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_cmd beats=%0d exp=%0d shfn=%0d exp=%0d held=%b", t, obs_d.size(), nb, got_shfn, exp_n, held_ok);
                continue;
            end
            for (int b = 0; b < nb; b++) begin
                k = (reps == 0) ? 0 : b + 1;
                e = model_beat(d, int'(amt), left, k);
                n_checks++;
                if (obs_d[b] !== e || obs_l[b] !== (b == nb - 1) || obs_lat[b] != ((reps == 0) ? 1 : 2)) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d got=%h/%b/%0d exp=%h/%b/%0d", t, b, obs_d[b], obs_l[b], obs_lat[b], e, b == nb - 1, (reps == 0) ? 1 : 2);
                end
            end
            n_checks++; if (ready_after !== 1'b1 || idle_after !== 1'b1) begin n_fail++; $display("FAIL rand%0d_idle got=%b/%b exp=1/1", t, ready_after, idle_after); end
        end
    endtask

    initial begin
        test_reset();
        test_right_rotate();
        test_left_repeat();
        test_backpressure();
        test_boundaries();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
